// File: rtl/fw_config_broadcaster.sv
// Firmware config bus transmitter: queues host write commands and broadcasts each one as a framed byte sequence.
// Optional checksum byte per frame when FW_CONFIG_CHECKSUM_EN is defined.
module fw_config_broadcaster #(
   parameter int         MAX_CHAINS     = 4,
   parameter int         CMD_FIFO_DEPTH = 4,
   parameter logic [7:0] IDLE_ID        = 8'hFF
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          tracing,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [7:0]                    cmd_target,
   input  logic [1:0]                    cmd_field,
   input  logic [$clog2(MAX_CHAINS)-1:0] cmd_chain,
   input  logic [7:0]                    cmd_value,
   output logic [7:0]                    configId,
   output logic [7:0]                    configData,
   output logic                          busy,
   output logic                          cmd_error,
   output logic [15:0]                   frames_sent
);

   localparam int CW = $clog2(MAX_CHAINS);
   localparam int PW = $clog2(CMD_FIFO_DEPTH);
   localparam int EW = 18 + CW;

   typedef enum logic [2:0] {S_IDLE, S_HDR, S_CHAIN, S_VALUE, S_CSUM, S_GAP} state_t;

   logic [EW-1:0] fifo_mem [CMD_FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q, count_d;
   logic [EW-1:0] cur_q, cur_d;
   state_t        state_q, state_d;
   logic [7:0]    id_q, id_d, data_q, data_d;
   logic          err_q, err_d;
   logic [15:0]   frames_q, frames_d;
   logic          fifo_empty, fifo_full, accept, cmd_bad, push, pop;
   logic [7:0]    hdr_byte, chain_byte, value_byte, target_byte;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == (PW+1)'(CMD_FIFO_DEPTH));
   assign cmd_ready  = !fifo_full;
   assign accept     = cmd_valid && cmd_ready;
   assign cmd_bad    = (cmd_target == IDLE_ID) || (cmd_field == 2'd3);
   assign push       = accept && !cmd_bad;

   assign configId    = id_q;
   assign configData  = data_q;
   assign cmd_error   = err_q;
   assign frames_sent = frames_q;
   assign busy        = !fifo_empty || (state_q != S_IDLE);

   // Command storage carries no reset; validity is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q] <= {cmd_target, cmd_field, cmd_chain, cmd_value};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         cur_q    <= '0;
         id_q     <= IDLE_ID;
         data_q   <= '0;
         err_q    <= 1'b0;
         frames_q <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         cur_q    <= cur_d;
         id_q     <= id_d;
         data_q   <= data_d;
         err_q    <= err_d;
         frames_q <= frames_d;
      end
   end

   // tracing only gates frame starts, so it is looked at solely in IDLE and GAP.
   always_comb begin
      state_d  = state_q;
      pop      = 1'b0;
      frames_d = frames_q;
      case (state_q)
         S_IDLE, S_GAP: begin
            if (!fifo_empty && !tracing) begin
               pop     = 1'b1;
               state_d = S_HDR;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_HDR:   state_d = S_CHAIN;
         S_CHAIN: state_d = S_VALUE;
`ifdef FW_CONFIG_CHECKSUM_EN
         S_VALUE: state_d = S_CSUM;
         S_CSUM: begin
            state_d  = S_GAP;
            frames_d = frames_q + 16'd1;
         end
`else
         S_VALUE: begin
            state_d  = S_GAP;
            frames_d = frames_q + 16'd1;
         end
`endif
         default: state_d = S_IDLE;
      endcase

      cur_d    = pop  ? fifo_mem[rd_ptr_q] : cur_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      err_d    = accept && cmd_bad;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Outputs are registered from the next state so the bus byte lines up with the state it belongs to.
   always_comb begin
      target_byte = cur_d[EW-1 -: 8];
      hdr_byte    = {6'b0, cur_d[EW-9 -: 2]};
      chain_byte  = 8'(cur_d[CW+7:8]);
      value_byte  = cur_d[7:0];
      id_d        = IDLE_ID;
      data_d      = '0;
      case (state_d)
         S_HDR:   begin id_d = target_byte; data_d = hdr_byte;   end
         S_CHAIN: begin id_d = target_byte; data_d = chain_byte; end
         S_VALUE: begin id_d = target_byte; data_d = value_byte; end
         S_CSUM:  begin id_d = target_byte; data_d = hdr_byte ^ chain_byte ^ value_byte; end
         default: begin id_d = IDLE_ID;     data_d = '0;         end
      endcase
   end

endmodule

// File: tb/tb_fw_config_broadcaster.sv
// Directed self-checking bench for fw_config_broadcaster; honours FW_CONFIG_CHECKSUM_EN when defined.
module tb_fw_config_broadcaster;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        tracing = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [7:0]  cmd_target = '0;
   logic [1:0]  cmd_field = '0;
   logic [1:0]  cmd_chain = '0;
   logic [7:0]  cmd_value = '0;
   logic [7:0]  configId, configData;
   logic        busy, cmd_error;
   logic [15:0] frames_sent;

   int total = 0;
   int bad = 0;

   fw_config_broadcaster dut (
      .clk(clk), .rst_n(rst_n), .tracing(tracing),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_target(cmd_target), .cmd_field(cmd_field),
      .cmd_chain(cmd_chain), .cmd_value(cmd_value),
      .configId(configId), .configData(configData),
      .busy(busy), .cmd_error(cmd_error), .frames_sent(frames_sent)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input string tag, input logic [7:0] id, input logic [7:0] d);
      tick();
      check_eq({tag, ".id"}, configId, id);
      check_eq({tag, ".data"}, configData, d);
   endtask

   task automatic set_cmd(input logic [7:0] t, input logic [1:0] f, input logic [1:0] c, input logic [7:0] v);
      cmd_target = t; cmd_field = f; cmd_chain = c; cmd_value = v;
      cmd_valid = 1'b1;
   endtask

   task automatic send(input logic [7:0] t, input logic [1:0] f, input logic [1:0] c, input logic [7:0] v);
      int n = 0;
      set_cmd(t, f, c, v);
      while (!cmd_ready && n < 20) begin
         tick();
         n++;
      end
      check_eq("send.ready", cmd_ready, 1);
      tick();
      cmd_valid = 1'b0;
      $display("cmd sent target=%02h field=%0d chain=%0d value=%02h", t, f, c, v);
   endtask

   task automatic check_frame(input string tag, input logic [7:0] t, input logic [1:0] f,
                              input logic [1:0] c, input logic [7:0] v);
      cyc({tag, ".hdr"}, t, {6'b0, f});
      cyc({tag, ".chain"}, t, {6'b0, c});
      cyc({tag, ".value"}, t, v);
`ifdef FW_CONFIG_CHECKSUM_EN
      cyc({tag, ".csum"}, t, {6'b0, f} ^ {6'b0, c} ^ v);
`endif
      cyc({tag, ".gap"}, 8'hFF, 8'h00);
      $display("frame checked %s target=%02h", tag, t);
   endtask

   initial begin
      // reset state
      tick(); tick();
      check_eq("rst.id", configId, 8'hFF);
      check_eq("rst.data", configData, 8'h00);
      check_eq("rst.ready", cmd_ready, 1);
      check_eq("rst.busy", busy, 0);
      check_eq("rst.err", cmd_error, 0);
      check_eq("rst.frames", frames_sent, 0);
      rst_n = 1'b1;
      tick();

      // single command
      send(8'h02, 2'd1, 2'd3, 8'h05);
      check_eq("t1.idle_id", configId, 8'hFF);
      check_eq("t1.busy", busy, 1);
      check_frame("t1", 8'h02, 2'd1, 2'd3, 8'h05);
      check_eq("t1.frames", frames_sent, 1);
      tick();
      check_eq("t1.busy_after", busy, 0);

      // fill FIFO under tracing, fifth held
      tracing = 1'b1;
      for (int i = 0; i < 4; i++) begin
         set_cmd(8'h10 + 8'(i), 2'(i % 3), 2'(i), 8'hA0 + 8'(i));
         check_eq("t2.ready_push", cmd_ready, 1);
         tick();
         $display("cmd pushed target=%02h", 8'h10 + 8'(i));
      end
      set_cmd(8'h14, 2'd2, 2'd1, 8'hB4);
      check_eq("t2.ready_full", cmd_ready, 0);
      tick(); tick();
      check_eq("t2.ready_held", cmd_ready, 0);
      check_eq("t2.id_tracing", configId, 8'hFF);
      check_eq("t2.busy", busy, 1);
      tracing = 1'b0;
      cyc("t2a.hdr", 8'h10, 8'h00);
      check_eq("t2.ready_after_pop", cmd_ready, 1);
      cyc("t2a.chain", 8'h10, 8'h00);
      cmd_valid = 1'b0;
      $display("cmd pushed target=14");
      cyc("t2a.value", 8'h10, 8'hA0);
`ifdef FW_CONFIG_CHECKSUM_EN
      cyc("t2a.csum", 8'h10, 8'hA0);
`endif
      cyc("t2a.gap", 8'hFF, 8'h00);
      check_frame("t2b", 8'h11, 2'd1, 2'd1, 8'hA1);
      check_frame("t2c", 8'h12, 2'd2, 2'd2, 8'hA2);
      check_frame("t2d", 8'h13, 2'd0, 2'd3, 8'hA3);
      check_frame("t2e", 8'h14, 2'd2, 2'd1, 8'hB4);
      check_eq("t2.frames", frames_sent, 6);
      tick();
      check_eq("t2.busy_end", busy, 0);

      // tracing rises mid-frame
      send(8'h30, 2'd0, 2'd2, 8'h33);
      set_cmd(8'h31, 2'd1, 2'd0, 8'h44);
      cyc("t3x.hdr", 8'h30, 8'h00);
      cmd_valid = 1'b0;
      cyc("t3x.chain", 8'h30, 8'h02);
      tracing = 1'b1;
      cyc("t3x.value", 8'h30, 8'h33);
`ifdef FW_CONFIG_CHECKSUM_EN
      cyc("t3x.csum", 8'h30, 8'h31);
`endif
      cyc("t3x.gap", 8'hFF, 8'h00);
      for (int i = 0; i < 3; i++) cyc("t3.hold", 8'hFF, 8'h00);
      check_eq("t3.busy_hold", busy, 1);
      tracing = 1'b0;
      check_frame("t3y", 8'h31, 2'd1, 2'd0, 8'h44);
      check_eq("t3.frames", frames_sent, 8);

      // rejected commands
      send(8'hFF, 2'd0, 2'd0, 8'h11);
      check_eq("t4.err1", cmd_error, 1);
      check_eq("t4.busy1", busy, 0);
      tick();
      check_eq("t4.err1_clear", cmd_error, 0);
      send(8'h20, 2'd3, 2'd1, 8'h22);
      check_eq("t4.err2", cmd_error, 1);
      tick();
      check_eq("t4.err2_clear", cmd_error, 0);
      for (int i = 0; i < 3; i++) cyc("t4.idle", 8'hFF, 8'h00);
      check_eq("t4.frames", frames_sent, 8);

      // asynchronous reset during VALUE with two queued
      send(8'h40, 2'd1, 2'd1, 8'h55);
      set_cmd(8'h41, 2'd0, 2'd0, 8'h66);
      tick();
      set_cmd(8'h42, 2'd0, 2'd0, 8'h77);
      tick();
      cmd_valid = 1'b0;
      cyc("t5.value", 8'h40, 8'h55);
      #2 rst_n = 1'b0;
      #1;
      check_eq("t5.rst_id", configId, 8'hFF);
      check_eq("t5.rst_data", configData, 8'h00);
      check_eq("t5.rst_busy", busy, 0);
      check_eq("t5.rst_frames", frames_sent, 0);
      tick(); tick();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) cyc("t5.after", 8'hFF, 8'h00);
      check_eq("t5.busy", busy, 0);
      check_eq("t5.frames", frames_sent, 0);
      check_eq("t5.ready", cmd_ready, 1);

`ifdef FW_CONFIG_CHECKSUM_EN
      send(8'h01, 2'd2, 2'd1, 8'hA0);
      cyc("t6.hdr", 8'h01, 8'h02);
      cyc("t6.chain", 8'h01, 8'h01);
      cyc("t6.value", 8'h01, 8'hA0);
      cyc("t6.csum", 8'h01, 8'hA3);
      cyc("t6.gap", 8'hFF, 8'h00);
      check_eq("t6.frames", frames_sent, 1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
